// File: rtl/seq_alu_if.sv
// Request/response bundle between the Y-register/bus datapath and seq_alu_core.
// The datapath side drives start/op/a/b; the ALU returns status and the ZHi/ZLo words.
interface seq_alu_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] zhi;
  logic [WIDTH-1:0] zlo;
  logic             carry;
  logic             dbz;
  logic             illegal;

  modport master (
    output start, op, a, b,
    input  busy, done, zhi, zlo, carry, dbz, illegal
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, zhi, zlo, carry, dbz, illegal
  );
endinterface

// File: rtl/seq_alu_core.sv
// Multi-cycle ALU: single-cycle logic/shift/add ops, radix-2 Booth multiply and
// signed restoring divide, with results registered into ZHi/ZLo-style outputs.
module seq_alu_core #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic      Clock,
  input logic      Clear,
  seq_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_e;

  typedef enum logic [3:0] {
    OP_AND = 4'd0,
    OP_OR  = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_DIV = 4'd5,
    OP_SHR = 4'd6,
    OP_SHL = 4'd7,
    OP_ROR = 4'd8,
    OP_ROL = 4'd9,
    OP_NEG = 4'd10,
    OP_NOT = 4'd11
  } op_e;

  state_e           state;
  logic [CW-1:0]    cnt;
  logic             is_div;

  // Booth datapath: acc carries one guard bit so a most-negative multiplicand cannot overflow
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   mcand;
  logic [WIDTH-1:0] mq;
  logic             qm1;

  // Restoring divider on magnitudes; signs re-applied in FIX
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvsr;
  logic             a_neg;
  logic             q_neg;

  logic [SHW-1:0]   sh;
  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] sc_lo;
  logic             sc_carry;
  logic             sc_ill;

  logic [WIDTH:0]   bsum;
  logic [WIDTH:0]   acc_n;
  logic [WIDTH-1:0] mq_n;

  logic [WIDTH:0]   dtrial;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;

  always_comb begin
    sh       = bus.b[SHW-1:0];
    add_s    = {1'b0, bus.a} + {1'b0, bus.b};
    sc_lo    = '0;
    sc_carry = 1'b0;
    sc_ill   = 1'b0;
    case (bus.op)
      OP_AND: sc_lo = bus.a & bus.b;
      OP_OR:  sc_lo = bus.a | bus.b;
      OP_ADD: begin
        sc_lo    = add_s[WIDTH-1:0];
        sc_carry = add_s[WIDTH];
      end
      OP_SUB: begin
        sc_lo    = bus.a - bus.b;
        sc_carry = (bus.a >= bus.b);
      end
      OP_SHR: sc_lo = bus.a >> sh;
      OP_SHL: sc_lo = bus.a << sh;
      OP_ROR: sc_lo = (bus.a >> sh) | (bus.a << (WIDTH - int'(sh)));
      OP_ROL: sc_lo = (bus.a << sh) | (bus.a >> (WIDTH - int'(sh)));
      OP_NEG: sc_lo = -bus.b;
      OP_NOT: sc_lo = ~bus.b;
      OP_MUL, OP_DIV: sc_lo = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  always_comb begin
    case ({mq[0], qm1})
      2'b01:   bsum = acc + mcand;
      2'b10:   bsum = acc - mcand;
      default: bsum = acc;
    endcase
    acc_n = {bsum[WIDTH], bsum[WIDTH:1]};
    mq_n  = {bsum[0], mq[WIDTH-1:1]};
  end

  always_comb begin
    dtrial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
    if (dtrial[WIDTH]) begin
      rem_n = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_n = dtrial[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state       <= IDLE;
      cnt         <= '0;
      is_div      <= 1'b0;
      acc         <= '0;
      mcand       <= '0;
      mq          <= '0;
      qm1         <= 1'b0;
      rem         <= '0;
      quo         <= '0;
      dvsr        <= '0;
      a_neg       <= 1'b0;
      q_neg       <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.zhi     <= '0;
      bus.zlo     <= '0;
      bus.carry   <= 1'b0;
      bus.dbz     <= 1'b0;
      bus.illegal <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MUL) begin
              mcand    <= {bus.a[WIDTH-1], bus.a};
              acc      <= '0;
              mq       <= bus.b;
              qm1      <= 1'b0;
              cnt      <= CW'(WIDTH);
              is_div   <= 1'b0;
              bus.busy <= 1'b1;
              state    <= RUN;
            end else if (bus.op == OP_DIV && bus.b != '0) begin
              rem      <= '0;
              quo      <= bus.a[WIDTH-1] ? -bus.a : bus.a;
              dvsr     <= bus.b[WIDTH-1] ? -bus.b : bus.b;
              a_neg    <= bus.a[WIDTH-1];
              q_neg    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              cnt      <= CW'(WIDTH);
              is_div   <= 1'b1;
              bus.busy <= 1'b1;
              state    <= RUN;
            end else if (bus.op == OP_DIV) begin
              bus.zhi     <= bus.a;
              bus.zlo     <= '0;
              bus.carry   <= 1'b0;
              bus.dbz     <= 1'b1;
              bus.illegal <= 1'b0;
              bus.done    <= 1'b1;
              state       <= DONE;
            end else begin
              bus.zhi     <= '0;
              bus.zlo     <= sc_lo;
              bus.carry   <= sc_carry;
              bus.dbz     <= 1'b0;
              bus.illegal <= sc_ill;
              bus.done    <= 1'b1;
              state       <= DONE;
            end
          end
        end
        RUN: begin
          cnt <= cnt - CW'(1);
          if (is_div) begin
            rem <= rem_n;
            quo <= quo_n;
            if (cnt == CW'(1)) state <= FIX;
          end else begin
            acc <= acc_n;
            mq  <= mq_n;
            qm1 <= mq[0];
            // Last Booth step: capture the product straight from the next-state terms
            if (cnt == CW'(1)) begin
              bus.zhi     <= acc_n[WIDTH-1:0];
              bus.zlo     <= mq_n;
              bus.carry   <= 1'b0;
              bus.dbz     <= 1'b0;
              bus.illegal <= 1'b0;
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
              state       <= DONE;
            end
          end
        end
        FIX: begin
          bus.zlo     <= q_neg ? -quo : quo;
          bus.zhi     <= a_neg ? -rem : rem;
          bus.carry   <= 1'b0;
          bus.dbz     <= 1'b0;
          bus.illegal <= 1'b0;
          bus.busy    <= 1'b0;
          bus.done    <= 1'b1;
          state       <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_core.sv
// Randomised scoreboard bench for seq_alu_core against a plain-arithmetic reference model.
module tb_seq_alu_core;
  localparam int W = 32;

  logic Clock = 1'b0;
  logic Clear;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu_core #(.WIDTH(W)) dut (
    .Clock(Clock),
    .Clear(Clear),
    .bus  (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         c;
    logic         z;
    logic         ill;
    int           lat;
    int           scyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint sa, sbv, p, q, r, u;
    logic [W-1:0] t;
    int unsigned n;
    e.op = op; e.hi = '0; e.lo = '0; e.c = 1'b0; e.z = 1'b0; e.ill = 1'b0;
    e.lat = 1; e.scyc = 0;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    n   = b % W;
    t   = a;
    case (op)
      4'd0: e.lo = a & b;
      4'd1: e.lo = a | b;
      4'd2: begin
        u = longint'(a) + longint'(b);
        e.lo = u[W-1:0];
        e.c  = (u >= 64'h1_0000_0000);
      end
      4'd3: begin
        e.lo = a - b;
        e.c  = (a >= b);
      end
      4'd4: begin
        p = sa * sbv;
        {e.hi, e.lo} = p;
        e.lat = W + 1;
      end
      4'd5: begin
        if (b == 0) begin
          e.hi = a;
          e.z  = 1'b1;
        end else begin
          q = sa / sbv;
          r = sa % sbv;
          e.lo = q[W-1:0];
          e.hi = r[W-1:0];
          e.lat = W + 2;
        end
      end
      4'd6: e.lo = a >> n;
      4'd7: e.lo = a << n;
      4'd8: begin
        repeat (n) t = {t[0], t[W-1:1]};
        e.lo = t;
      end
      4'd9: begin
        repeat (n) t = {t[W-2:0], t[W-1]};
        e.lo = t;
      end
      4'd10: e.lo = 0 - b;
      4'd11: e.lo = ~b;
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic [W-1:0] rval();
    case ($urandom_range(0, 9))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: every done pulse consumes exactly one scoreboard entry
  always @(negedge Clock) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("zhi op%0d", mon_e.op), bus.zhi, mon_e.hi);
        chk($sformatf("zlo op%0d", mon_e.op), bus.zlo, mon_e.lo);
        chk($sformatf("carry op%0d", mon_e.op), bus.carry, mon_e.c);
        chk($sformatf("dbz op%0d", mon_e.op), bus.dbz, mon_e.z);
        chk($sformatf("illegal op%0d", mon_e.op), bus.illegal, mon_e.ill);
        chk($sformatf("latency op%0d", mon_e.op), cyc - mon_e.scyc + 1, mon_e.lat);
        chk($sformatf("busy_at_done op%0d", mon_e.op), bus.busy, 0);
      end
    end
  end

  // mode 0: plain; 1: start pulse and operand change while busy; 2: start held into DONE
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int mode);
    exp_t e;
    int   busy_n;
    bit   seen;
    e = model(op, a, b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge Clock); #1;
    e.scyc = cyc;
    sb.push_back(e);
    if (mode != 2) bus.start = 1'b0;
    busy_n = 0;
    seen   = 1'b0;
    for (int k = 1; k <= 100 && !seen; k++) begin
      @(negedge Clock);
      if (mode == 1) begin
        if (k == 5) begin
          bus.start = 1'b1;
          bus.op    = 4'd2;
        end
        if (k == 6) bus.start = 1'b0;
        if (k == 10) begin
          bus.a = $urandom;
          bus.b = $urandom;
        end
      end
      if (bus.done === 1'b1) seen = 1'b1;
      else if (bus.busy === 1'b1) busy_n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout op%0d: got no done within 100 cycles, required done", op);
      sb.delete();
    end else begin
      chk($sformatf("busy_cycles op%0d", op), busy_n, e.lat - 1);
    end
    @(posedge Clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_zhi"}, bus.zhi, 0);
    chk({tag, "_zlo"}, bus.zlo, 0);
    chk({tag, "_carry"}, bus.carry, 0);
    chk({tag, "_dbz"}, bus.dbz, 0);
    chk({tag, "_illegal"}, bus.illegal, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]   rop;
    logic [W-1:0] ra, rb;
    bit           seen_done;

    Clear = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (2) @(posedge Clock);
    #1;
    check_zero("reset");
    @(negedge Clock) Clear = 1'b0;
    @(posedge Clock); #1;

    run_op(4'd4, 32'hFFFF_FFFA, 32'h0000_0007, 0);
    run_op(4'd5, 32'hFFFF_FFEF, 32'h0000_0005, 0);
    run_op(4'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(4'd2, 32'hFFFF_FFFF, 32'h0000_0001, 0);
    run_op(4'd8, 32'h8000_0001, 32'h0000_0001, 0);
    run_op(4'd10, 32'h1234_5678, 32'h0000_0005, 0);
    run_op(4'd5, 32'h0000_1234, 32'h0000_0000, 0);
    run_op(4'd13, 32'hDEAD_BEEF, 32'h1234_5678, 0);
    run_op(4'd4, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(4'd4, 32'h8000_0000, 32'h7FFF_FFFF, 0);
    run_op(4'd3, 32'h0000_0005, 32'h0000_0007, 0);
    run_op(4'd3, 32'h0000_0007, 32'h0000_0005, 0);
    run_op(4'd3, 32'h0000_0005, 32'h0000_0005, 0);
    run_op(4'd9, 32'h8000_0001, 32'h0000_0021, 0);
    run_op(4'd2, 32'h0000_0001, 32'h0000_0002, 2);
    run_op(4'd4, 32'hFFFF_FFFA, 32'h0000_0007, 1);
    run_op(4'd11, 32'h0, 32'h0F0F_0000, 0);

    // Abort a divide with Clear: outputs drop at once and no done follows
    bus.start = 1'b1; bus.op = 4'd5; bus.a = 32'hFFFF_FFEF; bus.b = 32'h5;
    @(posedge Clock); #1;
    bus.start = 1'b0;
    seen_done = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge Clock);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    Clear = 1'b1;
    #1;
    check_zero("clear_abort");
    repeat (2) @(posedge Clock);
    @(negedge Clock) Clear = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock);
      if (bus.done === 1'b1) seen_done = 1'b1;
    end
    chk("clear_no_done", seen_done, 0);
    @(posedge Clock); #1;
    run_op(4'd0, 32'h0000_F0F0, 32'h0000_0FF0, 0);

    for (int i = 0; i < 60; i++) begin
      rop = 4'($urandom_range(0, 15));
      ra  = rval();
      rb  = rval();
      if (rop == 4'd5 && $urandom_range(0, 4) == 0) rb = '0;
      run_op(rop, ra, rb, 0);
    end

    repeat (3) @(posedge Clock);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
